cla_add_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. It is built from 4-bit lookahead groups, and each group produces block propagate/generate. Groups are resolved a fixed number per pipeline stage, with the inter-stage carry held in a register. A valid/ready handshake makes it a drop-in arithmetic unit for the datapath, with sum, carry, overflow and zero flags.

---
 rtl/cla_add_pipe.sv | 143 ++++++++++++++
 tb/tb_cla_add_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: pipelined carry-lookahead adder/subtractor built from 4-bit
// lookahead groups. Each stage resolves GPS groups and hands the carry, the
// partial sum and the still-unresolved operand bits to the next stage.
// A single global enable freezes the whole pipe while the output is stalled.
module cla_add_pipe #(
    parameter int WIDTH = 16,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / 4;
    localparam int L  = (NG + GPS - 1) / GPS;

    logic w_en;
    logic r_ovf;
    logic r_zero;

    assign w_en     = !out_valid | out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int FIRST = k * GPS;
        localparam int LAST  = ((k + 1) * GPS < NG) ? (k + 1) * GPS : NG;

        logic [WIDTH-1:0] w_aIn;
        logic [WIDTH-1:0] w_bIn;
        logic [WIDTH-1:0] w_sIn;
        logic             w_cIn;
        logic             w_vIn;
        logic [WIDTH-1:0] w_sOut;
        logic             w_cOut;
        logic             w_cMsb;
        logic [3:0]       w_p;
        logic [3:0]       w_g;
        logic [3:0]       w_c;
        logic             w_carry;
        logic             w_grpP;
        logic             w_grpG;

        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_s;
        logic             r_c;
        logic             r_v;

        // The first stage folds subtraction into b' and the forced carry-in;
        // later stages take everything from the previous stage registers.
        if (k == 0) begin : g_in
            assign w_aIn = a;
            assign w_bIn = sub ? ~b : b;
            assign w_sIn = '0;
            assign w_cIn = sub | cin;
            assign w_vIn = in_valid;
        end else begin : g_in
            assign w_aIn = g_stage[k-1].r_a;
            assign w_bIn = g_stage[k-1].r_b;
            assign w_sIn = g_stage[k-1].r_s;
            assign w_cIn = g_stage[k-1].r_c;
            assign w_vIn = g_stage[k-1].r_v;
        end

        // Resolve this stage's groups: full 4-bit lookahead inside each group,
        // then group propagate/generate carries the chain to the next group.
        always_comb begin
            w_sOut  = w_sIn;
            w_carry = w_cIn;
            w_cMsb  = 1'b0;
            w_p     = '0;
            w_g     = '0;
            w_c     = '0;
            w_grpP  = 1'b0;
            w_grpG  = 1'b0;
            for (int grp = FIRST; grp < LAST; grp++) begin
                w_p    = w_aIn[grp*4 +: 4] ^ w_bIn[grp*4 +: 4];
                w_g    = w_aIn[grp*4 +: 4] & w_bIn[grp*4 +: 4];
                w_c[0] = w_carry;
                w_c[1] = w_g[0] | (w_p[0] & w_carry);
                w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_carry);
                w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_carry);
                w_grpP = &w_p;
                w_grpG = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
                w_sOut[grp*4 +: 4] = w_p ^ w_c;
                w_cMsb  = w_c[3];
                w_carry = w_grpG | (w_grpP & w_carry);
            end
            w_cOut = w_carry;
        end

        // Stage registers advance together on the global enable; data only
        // loads for a real operation so idle inputs never disturb the outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_a <= '0;
                r_b <= '0;
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_en) begin
                r_v <= w_vIn;
                if (w_vIn) begin
                    r_a <= w_aIn;
                    r_b <= w_bIn;
                    r_s <= w_sOut;
                    r_c <= w_cOut;
                end
            end
        end
    end

    // Flags are formed as the last group resolves, alongside its carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en && g_stage[L-1].w_vIn) begin
            r_ovf  <= g_stage[L-1].w_cMsb ^ g_stage[L-1].w_cOut;
            r_zero <= (g_stage[L-1].w_sOut == '0);
        end
    end

    assign sum       = g_stage[L-1].r_s;
    assign cout      = g_stage[L-1].r_c;
    assign out_valid = g_stage[L-1].r_v;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_add_pipe.sv
// tb_cla_add_pipe: directed vectors and handshake sequences on a 16-bit,
// two-groups-per-stage instance, plus randomized streams on a sweep of
// width/grouping configurations checked against an arithmetic model.
module tb_cla_add_pipe;

    localparam int MW   = 16;
    localparam int MLAT = 2;
    localparam int NCFG = 10;
    localparam int NOPS = 10000;
    localparam int CW [NCFG] = '{4, 16, 16, 16, 32, 32, 32, 64, 64, 64};
    localparam int CG [NCFG] = '{1,  1,  3,  4,  1,  3,  8,  1,  3, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic swRst = 1'b1;
    logic [NCFG-1:0] doneVec;

    int checks = 0;
    int failures = 0;

    logic          mInValid = 1'b0;
    logic          mInReady;
    logic [MW-1:0] mA = '0;
    logic [MW-1:0] mB = '0;
    logic          mCin = 1'b0;
    logic          mSub = 1'b0;
    logic          mOutValid;
    logic          mOutReady = 1'b1;
    logic [MW-1:0] mSum;
    logic          mCout;
    logic          mOvf;
    logic          mZero;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    always #5 clk = ~clk;

    cla_add_pipe #(.WIDTH(MW), .GPS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(mInValid), .in_ready(mInReady),
        .a(mA), .b(mB), .cin(mCin), .sub(mSub),
        .out_valid(mOutValid), .out_ready(mOutReady),
        .sum(mSum), .cout(mCout), .ovf(mOvf), .zero(mZero)
    );

    // Compare one observed value against its expectation and log a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result as plain modular arithmetic: {cout, ovf, zero, sum}.
    function automatic logic [66:0] refModel(input int w, input logic [63:0] av, input logic [63:0] bv,
                                             input logic cv, input logic sv);
        logic [63:0] m;
        logic [64:0] bb;
        logic [64:0] full;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bb   = {1'b0, (sv ? ~bv : bv) & m};
        full = {1'b0, av & m} + bb + {64'd0, (sv ? 1'b1 : cv)};
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
        z    = (s == 64'd0);
        return {co, ov, z, s};
    endfunction

    // Present one operation at a falling edge and count cycles until it emerges.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                                 input logic sv, output int lat);
        mA = av;
        mB = bv;
        mCin = cv;
        mSub = sv;
        mInValid = 1'b1;
        mOutReady = 1'b1;
        @(negedge clk);
        mInValid = 1'b0;
        lat = 1;
        while (!mOutValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Randomized streams with random stalls on each swept configuration.
    for (genvar ci = 0; ci < NCFG; ci++) begin : g_sw
        localparam int W   = CW[ci];
        localparam int G   = CG[ci];
        localparam int LAT = ((W / 4) + G - 1) / G;

        logic         inV = 1'b0;
        logic         inR;
        logic         outV;
        logic         outR = 1'b1;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         c = 1'b0;
        logic         s = 1'b0;
        logic [W-1:0] sm;
        logic         co;
        logic         ov;
        logic         z;
        logic         done = 1'b0;
        logic [66:0]  expQ [$];

        cla_add_pipe #(.WIDTH(W), .GPS(G)) dut (
            .clk(clk), .rst(swRst), .in_valid(inV), .in_ready(inR),
            .a(a), .b(b), .cin(c), .sub(s),
            .out_valid(outV), .out_ready(outR),
            .sum(sm), .cout(co), .ovf(ov), .zero(z)
        );

        assign doneVec[ci] = done;

        initial begin
            int sent;
            int cyc;
            int lat;
            logic [66:0] e;
            string tag;
            sent = 0;
            cyc = 0;
            tag = $sformatf("sweep W%0d G%0d", W, G);
            while (swRst) @(negedge clk);

            a = W'({$urandom(), $urandom()});
            b = W'({$urandom(), $urandom()});
            c = 1'($urandom());
            s = 1'($urandom());
            inV = 1'b1;
            outR = 1'b1;
            e = refModel(W, 64'(a), 64'(b), c, s);
            @(negedge clk);
            inV = 1'b0;
            lat = 1;
            while (!outV && lat < LAT + 4) begin
                @(negedge clk);
                lat++;
            end
            checkOutput({tag, " latency"}, 64'(lat), 64'(LAT));
            checkOutput({tag, " first sum"}, 64'(sm), e[63:0]);
            checkOutput({tag, " first flags"}, {61'd0, co, ov, z}, {61'd0, e[66:64]});

            while ((sent < NOPS || expQ.size() != 0) && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                inV = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                a = W'({$urandom(), $urandom()});
                b = W'({$urandom(), $urandom()});
                c = 1'($urandom());
                s = 1'($urandom());
                outR = ($urandom_range(0, 3) != 0);
                #1;
                if (inV && inR) begin
                    expQ.push_back(refModel(W, 64'(a), 64'(b), c, s));
                    sent++;
                end
                if (outV && outR) begin
                    if (expQ.size() == 0) begin
                        checkOutput({tag, " unexpected result"}, 64'(outV), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({tag, " sum"}, 64'(sm), e[63:0]);
                        checkOutput({tag, " flags"}, {61'd0, co, ov, z}, {61'd0, e[66:64]});
                    end
                end
            end
            checkOutput({tag, " ops sent"}, 64'(sent), 64'(NOPS));
            checkOutput({tag, " results outstanding"}, 64'(expQ.size()), 64'd0);
            inV = 1'b0;
            done = 1'b1;
        end
    end

    // Directed tests on the 16-bit instance, then wait for the sweep and summarize.
    initial begin
        vec_t vecs [10];
        int lat;
        int x;
        int got;
        int stallLeft;
        int res [$];
        logic [15:0] heldSum;
        logic heldCout;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0007, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mA = 16'($urandom());
            mB = 16'($urandom());
            mCin = 1'($urandom());
            mSub = 1'($urandom());
            mInValid = 1'($urandom());
            mOutReady = 1'($urandom());
        end
        @(negedge clk);
        rst = 1'b0;
        swRst = 1'b0;
        mInValid = 1'b0;
        mOutReady = 1'b1;
        #1;
        checkOutput("reset out_valid", 64'(mOutValid), 64'd0);
        checkOutput("reset sum", 64'(mSum), 64'd0);
        checkOutput("reset flags", {61'd0, mCout, mOvf, mZero}, 64'd0);
        checkOutput("reset in_ready", 64'(mInReady), 64'd1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(MLAT));
            checkOutput($sformatf("vec%0d sum", i), 64'(mSum), 64'(vecs[i].sum));
            checkOutput($sformatf("vec%0d cout", i), 64'(mCout), 64'(vecs[i].cout));
            checkOutput($sformatf("vec%0d ovf", i), 64'(mOvf), 64'(vecs[i].ovf));
            checkOutput($sformatf("vec%0d zero", i), 64'(mZero), 64'(vecs[i].zero));
        end

        $display("[TB] back-to-back stream with a 3-cycle stall");
        x = 1;
        got = 0;
        stallLeft = 3;
        heldSum = '0;
        heldCout = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            mInValid = (x <= 6);
            mA = 16'(x);
            mB = 16'(x);
            mCin = 1'b0;
            mSub = 1'b0;
            mOutReady = !(got == 2 && stallLeft > 0);
            #1;
            if (!mOutReady && mOutValid) begin
                checkOutput("stall in_ready", 64'(mInReady), 64'd0);
                if (stallLeft == 3) begin
                    heldSum = mSum;
                    heldCout = mCout;
                end else begin
                    checkOutput("stall sum held", 64'(mSum), 64'(heldSum));
                    checkOutput("stall cout held", 64'(mCout), 64'(heldCout));
                end
                stallLeft--;
            end
            if (mInValid && mInReady) x++;
            if (mOutValid && mOutReady) begin
                res.push_back(int'(mSum));
                got++;
            end
        end
        mInValid = 1'b0;
        mOutReady = 1'b1;
        checkOutput("stream stall cycles", 64'(stallLeft), 64'd0);
        checkOutput("stream result count", 64'(res.size()), 64'd6);
        for (int i = 0; i < res.size(); i++) begin
            checkOutput($sformatf("stream result %0d", i), 64'(res[i]), 64'(2 * (i + 1)));
        end

        $display("[TB] reset with two operations in flight");
        @(negedge clk);
        mA = 16'h0011;
        mB = 16'h0022;
        mSub = 1'b0;
        mInValid = 1'b1;
        @(negedge clk);
        mA = 16'h0033;
        @(negedge clk);
        mInValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput($sformatf("flush out_valid cyc%0d", i), 64'(mOutValid), 64'd0);
            checkOutput($sformatf("flush sum cyc%0d", i), 64'(mSum), 64'd0);
            @(negedge clk);
        end

        $display("[TB] waiting for parameter sweep");
        for (int i = 0; i < 80000 && doneVec != {NCFG{1'b1}}; i++) @(negedge clk);
        checkOutput("sweep finished", 64'(doneVec), 64'({NCFG{1'b1}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
